// File: rtl/ddr2_local_multiport_arbiter.sv
// ============================================================================
//  Module   : ddr2_local_multiport_arbiter
//  Brief    : N-port round-robin front end for the DDR2 controller local
//             interface. Grants at burst granularity, holds the grant for a
//             whole write burst, and routes read data back to the issuing
//             port through an outstanding-read tag FIFO.
//  Options  : DDR2_ARB_PORT0_PRIO_EN - port 0 has strict priority in IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr2_local_multiport_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 32,
    parameter int BE_W         = 4,
    parameter int SIZE_W       = 3,
    parameter int RD_TAG_DEPTH = 8
) (
    input  logic                          phy_clk_i,
    input  logic                          reset_phy_clk_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_address_i,
    input  logic [NUM_PORTS-1:0]          p_read_req_i,
    input  logic [NUM_PORTS-1:0]          p_write_req_i,
    input  logic [NUM_PORTS-1:0]          p_burstbegin_i,
    input  logic [NUM_PORTS*SIZE_W-1:0]   p_size_i,
    input  logic [NUM_PORTS*BE_W-1:0]     p_be_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_wdata_i,
    output logic [NUM_PORTS-1:0]          p_ready_o,
    output logic [DATA_W-1:0]             p_rdata_o,
    output logic [NUM_PORTS-1:0]          p_rdata_valid_o,
    output logic [ADDR_W-1:0]             local_address_o,
    output logic                          local_read_req_o,
    output logic                          local_write_req_o,
    output logic                          local_burstbegin_o,
    output logic [SIZE_W-1:0]             local_size_o,
    output logic [BE_W-1:0]               local_be_o,
    output logic [DATA_W-1:0]             local_wdata_o,
    input  logic                          local_ready_i,
    input  logic [DATA_W-1:0]             local_rdata_i,
    input  logic                          local_rdata_valid_i,
    output logic                          rd_orphan_err_o
);

    localparam int              PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int              TAG_AW    = (RD_TAG_DEPTH > 1) ? $clog2(RD_TAG_DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST_PORT = PTR_W'(NUM_PORTS - 1);
    localparam logic [PTR_W-1:0]  PORT_ONE  = PTR_W'(1);
    localparam logic [TAG_AW:0]   TAG_FULL  = (TAG_AW + 1)'(RD_TAG_DEPTH);
    localparam logic [TAG_AW:0]   CNT_ONE   = (TAG_AW + 1)'(1);
    localparam logic [TAG_AW-1:0] TPTR_ONE  = TAG_AW'(1);
    localparam logic [SIZE_W-1:0] SIZE_ONE  = SIZE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_WBURST = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SIZE_W-1:0]   wcnt_q, wcnt_d;

    logic [PTR_W-1:0]    tag_port_q [RD_TAG_DEPTH];
    logic [SIZE_W-1:0]   tag_size_q [RD_TAG_DEPTH];
    logic [TAG_AW-1:0]   tag_wr_ptr_q, tag_rd_ptr_q;
    logic [TAG_AW:0]     tag_cnt_q;
    logic [SIZE_W-1:0]   rbeat_q, rbeat_d;
    logic                orphan_q, orphan_d;

    logic [ADDR_W-1:0]   addr_a  [NUM_PORTS];
    logic [SIZE_W-1:0]   size_a  [NUM_PORTS];
    logic [BE_W-1:0]     be_a    [NUM_PORTS];
    logic [DATA_W-1:0]   wdata_a [NUM_PORTS];

    logic [NUM_PORTS-1:0] req;
    logic [PTR_W-1:0]     pick;
    logic [PTR_W-1:0]     rr_next;
    logic                 sel_rd, sel_wr;
    logic [SIZE_W-1:0]    sel_size, sel_size_eff;
    logic                 tag_full, tag_empty;
    logic                 push, pop;
    logic [PTR_W-1:0]     head_port;
    logic [SIZE_W-1:0]    head_size;

    // Unpack the flattened per-port buses into arrays indexed by port number.
    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
            assign addr_a[i]  = p_address_i[i*ADDR_W +: ADDR_W];
            assign size_a[i]  = p_size_i[i*SIZE_W +: SIZE_W];
            assign be_a[i]    = p_be_i[i*BE_W +: BE_W];
            assign wdata_a[i] = p_wdata_i[i*DATA_W +: DATA_W];
        end
    endgenerate

    assign req          = p_read_req_i | p_write_req_i;
    assign sel_rd       = p_read_req_i[gnt_q];
    assign sel_wr       = p_write_req_i[gnt_q];
    assign sel_size     = size_a[gnt_q];
    assign sel_size_eff = (sel_size == '0) ? SIZE_ONE : sel_size;
    assign rr_next      = (gnt_q == LAST_PORT) ? '0 : gnt_q + PORT_ONE;
    assign tag_full     = (tag_cnt_q == TAG_FULL);
    assign tag_empty    = (tag_cnt_q == '0);
    assign head_port    = tag_port_q[tag_rd_ptr_q];
    assign head_size    = tag_size_q[tag_rd_ptr_q];
    assign p_rdata_o    = local_rdata_i;
    assign rd_orphan_err_o = orphan_q;

    // Pick the first requester at or after rr_ptr (port 0 first when prioritised).
    always_comb begin
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
`ifdef DDR2_ARB_PORT0_PRIO_EN
        if (req[0]) begin
            pick = '0;
        end
`endif
    end

    // Arbitration FSM: next state, grant bookkeeping and local-side muxing.
    always_comb begin
        state_d            = state_q;
        gnt_d              = gnt_q;
        rr_ptr_d           = rr_ptr_q;
        wcnt_d             = wcnt_q;
        push               = 1'b0;
        p_ready_o          = '0;
        local_address_o    = '0;
        local_read_req_o   = 1'b0;
        local_write_req_o  = 1'b0;
        local_burstbegin_o = 1'b0;
        local_size_o       = '0;
        local_be_o         = '0;
        local_wdata_o      = '0;

        if (state_q != ST_IDLE) begin
            local_address_o    = addr_a[gnt_q];
            local_burstbegin_o = p_burstbegin_i[gnt_q];
            local_size_o       = sel_size;
            local_be_o         = be_a[gnt_q];
            local_wdata_o      = wdata_a[gnt_q];
        end

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A read is withheld from the controller while no tag slot is free.
                local_read_req_o  = sel_rd & ~tag_full;
                local_write_req_o = sel_wr & ~sel_rd;
                p_ready_o[gnt_q]  = local_ready_i & ~(sel_rd & tag_full);
                if (!sel_rd && !sel_wr) begin
                    state_d = ST_IDLE;
                end else if (sel_rd) begin
                    if (local_ready_i && !tag_full) begin
                        push     = 1'b1;
                        state_d  = ST_IDLE;
                        rr_ptr_d = rr_next;
                    end
                end else if (local_ready_i) begin
                    if (sel_size_eff == SIZE_ONE) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = rr_next;
                    end else begin
                        wcnt_d  = sel_size_eff - SIZE_ONE;
                        state_d = ST_WBURST;
                    end
                end
            end
            ST_WBURST: begin
                // Grant is locked to the bursting port; reads are not forwarded.
                local_write_req_o = sel_wr;
                p_ready_o[gnt_q]  = local_ready_i;
                if (sel_wr && local_ready_i) begin
                    wcnt_d = wcnt_q - SIZE_ONE;
                    if (wcnt_q == SIZE_ONE) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = rr_next;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge phy_clk_i) begin
        if (reset_phy_clk_i) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Read return: steer valid to the head tag's port and count its beats.
    always_comb begin
        p_rdata_valid_o = '0;
        pop             = 1'b0;
        rbeat_d         = rbeat_q;
        orphan_d        = orphan_q;
        if (local_rdata_valid_i) begin
            if (tag_empty) begin
                orphan_d = 1'b1;
            end else begin
                p_rdata_valid_o[head_port] = 1'b1;
                if (rbeat_q + SIZE_ONE == head_size) begin
                    pop     = 1'b1;
                    rbeat_d = '0;
                end else begin
                    rbeat_d = rbeat_q + SIZE_ONE;
                end
            end
        end
    end

    // Tag FIFO pointers, occupancy, beat counter and sticky orphan flag.
    always_ff @(posedge phy_clk_i) begin
        if (reset_phy_clk_i) begin
            tag_wr_ptr_q <= '0;
            tag_rd_ptr_q <= '0;
            tag_cnt_q    <= '0;
            rbeat_q      <= '0;
            orphan_q     <= 1'b0;
        end else begin
            rbeat_q  <= rbeat_d;
            orphan_q <= orphan_d;
            if (push) begin
                tag_wr_ptr_q <= tag_wr_ptr_q + TPTR_ONE;
            end
            if (pop) begin
                tag_rd_ptr_q <= tag_rd_ptr_q + TPTR_ONE;
            end
            case ({push, pop})
                2'b10:   tag_cnt_q <= tag_cnt_q + CNT_ONE;
                2'b01:   tag_cnt_q <= tag_cnt_q - CNT_ONE;
                default: tag_cnt_q <= tag_cnt_q;
            endcase
        end
    end

    // Tag FIFO storage; the effective (non-zero) burst size is stored.
    always_ff @(posedge phy_clk_i) begin
        if (push) begin
            tag_port_q[tag_wr_ptr_q] <= gnt_q;
            tag_size_q[tag_wr_ptr_q] <= sel_size_eff;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr2_local_multiport_arbiter.sv
// ============================================================================
//  Module   : tb_ddr2_local_multiport_arbiter
//  Brief    : Self-checking bench for ddr2_local_multiport_arbiter. Masters
//             replay per-port command lists; a simple controller model
//             accepts commands and returns read beats. Expected grant order,
//             data routing and flags come from a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr2_local_multiport_arbiter;

    localparam int NP = 4;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int SW = 3;
    localparam int TD = 8;

    typedef struct {
        bit            rd;
        logic [SW-1:0] size;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        int port;
        int size;
    } rd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*AW-1:0]  p_address;
    logic [NP-1:0]     p_read_req, p_write_req, p_burstbegin;
    logic [NP*SW-1:0]  p_size;
    logic [NP*BW-1:0]  p_be;
    logic [NP*DW-1:0]  p_wdata;
    logic [NP-1:0]     p_ready;
    logic [DW-1:0]     p_rdata;
    logic [NP-1:0]     p_rdata_valid;
    logic [AW-1:0]     local_address;
    logic              local_read_req, local_write_req, local_burstbegin;
    logic [SW-1:0]     local_size;
    logic [BW-1:0]     local_be;
    logic [DW-1:0]     local_wdata;
    logic              local_ready;
    logic [DW-1:0]     local_rdata;
    logic              local_rdata_valid;
    logic              rd_orphan_err;

    ddr2_local_multiport_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .SIZE_W(SW), .RD_TAG_DEPTH(TD)
    ) dut (
        .phy_clk_i           (clk),
        .reset_phy_clk_i     (rst),
        .p_address_i         (p_address),
        .p_read_req_i        (p_read_req),
        .p_write_req_i       (p_write_req),
        .p_burstbegin_i      (p_burstbegin),
        .p_size_i            (p_size),
        .p_be_i              (p_be),
        .p_wdata_i           (p_wdata),
        .p_ready_o           (p_ready),
        .p_rdata_o           (p_rdata),
        .p_rdata_valid_o     (p_rdata_valid),
        .local_address_o     (local_address),
        .local_read_req_o    (local_read_req),
        .local_write_req_o   (local_write_req),
        .local_burstbegin_o  (local_burstbegin),
        .local_size_o        (local_size),
        .local_be_o          (local_be),
        .local_wdata_o       (local_wdata),
        .local_ready_i       (local_ready),
        .local_rdata_i       (local_rdata),
        .local_rdata_valid_i (local_rdata_valid),
        .rd_orphan_err_o     (rd_orphan_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // master command lists
    cmd_t cmds [NP][64];
    int   n_cmd [NP];
    int   head  [NP];
    int   beat  [NP];
    int   pulse_cnt [NP];

    // reference model state
    rd_t  rdq[$];
    int   rbeat;
    int   last_start;
    int   burst_owner;
    int   burst_left;
    bit   orphan_exp;

    // controller knobs
    int   ready_pct;
    int   ret_pct;
    bit   return_en;
    bit   orphan_pulse;

    // logs
    int          cyc;
    int          log_port[$];
    int          log_cyc[$];
    logic [NP-1:0] rv_log[$];
    int          first_ret_cyc;
    logic [NP-1:0] last_pready;

    function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic int eff(logic [SW-1:0] s);
        return (s == '0) ? 1 : int'(s);
    endfunction

    // Round-robin reference: first port with work left after the last starter.
    function automatic int next_port();
        int rr;
        int q;
`ifdef DDR2_ARB_PORT0_PRIO_EN
        if (head[0] < n_cmd[0]) return 0;
`endif
        rr = (last_start < 0) ? 0 : (last_start + 1) % NP;
        for (int k = 0; k < NP; k++) begin
            q = (rr + k) % NP;
            if (head[q] < n_cmd[q]) return q;
        end
        return -1;
    endfunction

    function automatic void clear_test();
        for (int p = 0; p < NP; p++) begin
            n_cmd[p] = 0; head[p] = 0; beat[p] = 0; pulse_cnt[p] = 0;
        end
        log_port.delete(); log_cyc.delete(); rv_log.delete();
        first_ret_cyc = -1;
    endfunction

    function automatic void add_cmd(int p, bit rd, int size);
        cmd_t c;
        c.rd   = rd;
        c.size = SW'(size);
        c.addr = AW'($urandom());
        c.be   = BW'($urandom());
        c.data = $urandom();
        cmds[p][n_cmd[p]] = c;
        n_cmd[p]++;
    endfunction

    task automatic drive_idle();
        p_address = '0; p_read_req = '0; p_write_req = '0; p_burstbegin = '0;
        p_size = '0; p_be = '0; p_wdata = '0;
        local_ready = 1'b0; local_rdata = '0; local_rdata_valid = 1'b0;
    endtask

    // One clock: drive at posedge+1, check and update model at negedge.
    task automatic step();
        cmd_t c;
        int   acc_p;
        int   nready;
        bit   do_push;
        rd_t  rp;
        for (int p = 0; p < NP; p++) begin
            if (head[p] < n_cmd[p]) begin
                c = cmds[p][head[p]];
                p_read_req[p]         = c.rd;
                p_write_req[p]        = !c.rd;
                p_burstbegin[p]       = (beat[p] == 0);
                p_size[p*SW +: SW]    = c.size;
                p_address[p*AW +: AW] = c.addr;
                p_be[p*BW +: BW]      = c.be;
                p_wdata[p*DW +: DW]   = c.data + DW'(beat[p]);
            end else begin
                p_read_req[p] = 1'b0; p_write_req[p] = 1'b0; p_burstbegin[p] = 1'b0;
                p_size[p*SW +: SW] = '0; p_address[p*AW +: AW] = '0;
                p_be[p*BW +: BW] = '0; p_wdata[p*DW +: DW] = '0;
            end
        end
        local_ready       = ($urandom_range(0, 99) < ready_pct);
        local_rdata_valid = orphan_pulse ||
                            (return_en && rdq.size() > 0 && $urandom_range(0, 99) < ret_pct);
        local_rdata       = $urandom();

        @(negedge clk);
        cyc++;
        last_pready = p_ready;
        acc_p  = -1;
        nready = 0;
        do_push = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (p_ready[p]) begin
                nready++;
                pulse_cnt[p]++;
                if (head[p] < n_cmd[p]) acc_p = p;
            end
        end
        chk("ready_onehot", 64'(nready <= 1), 64'(1));
        chk("local_accept", 64'(local_ready & (local_read_req | local_write_req)), 64'(acc_p >= 0));
        chk("orphan_flag", 64'(rd_orphan_err), 64'(orphan_exp));
        if (rdq.size() == TD) chk("rd_stall", 64'(local_read_req), 64'(0));

        if (acc_p >= 0) begin
            c = cmds[acc_p][head[acc_p]];
            chk("addr", 64'(local_address), 64'(c.addr));
            chk("rd_req", 64'(local_read_req), 64'(c.rd));
            chk("wr_req", 64'(local_write_req), 64'(!c.rd));
            chk("burstbegin", 64'(local_burstbegin), 64'(beat[acc_p] == 0));
            chk("size", 64'(local_size), 64'(c.size));
            chk("be", 64'(local_be), 64'(c.be));
            if (!c.rd) chk("wdata", 64'(local_wdata), 64'(c.data + DW'(beat[acc_p])));
            if (burst_left > 0) begin
                chk("burst_owner", 64'(acc_p), 64'(burst_owner));
                burst_left--;
            end else begin
                chk("grant_order", 64'(acc_p), 64'(next_port()));
                last_start = acc_p;
            end
            log_port.push_back(acc_p);
            log_cyc.push_back(cyc);
            if (c.rd) begin
                chk("tag_room", 64'(rdq.size() < TD), 64'(1));
                rp.port = acc_p;
                rp.size = eff(c.size);
                do_push = 1'b1;
                head[acc_p]++;
            end else begin
                if (beat[acc_p] == 0 && eff(c.size) > 1) begin
                    burst_owner = acc_p;
                    burst_left  = eff(c.size) - 1;
                end
                beat[acc_p]++;
                if (beat[acc_p] == eff(c.size)) begin
                    beat[acc_p] = 0;
                    head[acc_p]++;
                end
            end
        end

        if (local_rdata_valid) begin
            chk("rdata", 64'(p_rdata), 64'(local_rdata));
            if (rdq.size() == 0) begin
                chk("orphan_valid", 64'(p_rdata_valid), 64'(0));
                orphan_exp = 1'b1;
            end else begin
                chk("rvalid_port", 64'(p_rdata_valid), 64'(1) << rdq[0].port);
                rv_log.push_back(p_rdata_valid);
                if (first_ret_cyc < 0) first_ret_cyc = cyc;
                rbeat++;
                if (rbeat == rdq[0].size) begin
                    void'(rdq.pop_front());
                    rbeat = 0;
                end
            end
        end else begin
            chk("rvalid_idle", 64'(p_rdata_valid), 64'(0));
        end
        if (do_push) rdq.push_back(rp);

        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(int budget);
        int  n;
        bit  busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            step();
            n++;
            busy = (rdq.size() > 0);
            for (int p = 0; p < NP; p++) if (head[p] < n_cmd[p]) busy = 1'b1;
        end
        chk("drain_timeout", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        clear_test();
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        last_start = -1; rdq.delete(); rbeat = 0; orphan_exp = 1'b0;
        burst_left = 0; burst_owner = 0;
        @(negedge clk);
        chk("rst_p_ready", 64'(p_ready), 64'(0));
        chk("rst_rvalid", 64'(p_rdata_valid), 64'(0));
        chk("rst_local_req", 64'({local_read_req, local_write_req, local_burstbegin}), 64'(0));
        chk("rst_local_addr", 64'(local_address), 64'(0));
        chk("rst_orphan", 64'(rd_orphan_err), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc = 0;
        ready_pct = 100; ret_pct = 100; return_en = 1'b0; orphan_pulse = 1'b0;
        rst = 1'b1;
        drive_idle();
        do_reset();

        // four single writes, one per port
        clear_test();
        for (int p = 0; p < NP; p++) add_cmd(p, 1'b0, 1);
        run_until_idle(60);
        chk("t1_count", 64'(log_port.size()), 64'(4));
        for (int k = 0; k < NP; k++) begin
            if (k < log_port.size()) chk("t1_order", 64'(log_port[k]), 64'(k));
            chk("t1_pulses", 64'(pulse_cnt[k]), 64'(1));
        end

        // port1 burst of 4 while port2 waits
        clear_test();
        add_cmd(1, 1'b0, 4);
        add_cmd(2, 1'b0, 1);
        run_until_idle(60);
        chk("t2_count", 64'(log_port.size()), 64'(5));
        if (log_port.size() == 5) begin
            for (int k = 0; k < 4; k++) chk("t2_burst_port", 64'(log_port[k]), 64'(1));
            for (int k = 1; k < 4; k++) chk("t2_burst_gap", 64'(log_cyc[k] - log_cyc[k-1]), 64'(1));
            chk("t2_port2", 64'(log_port[4]), 64'(2));
            chk("t2_bubble", 64'(log_cyc[4] - log_cyc[3]), 64'(2));
        end

        // nine reads from port3 against an eight-entry tag FIFO
        clear_test();
        for (int k = 0; k < 9; k++) add_cmd(3, 1'b1, 1);
        return_en = 1'b0;
        repeat (30) step();
        chk("t3_accepted", 64'(head[3]), 64'(8));
        chk("t3_outstanding", 64'(rdq.size()), 64'(8));
        chk("t3_stalled", 64'(last_pready[3]), 64'(0));
        return_en = 1'b1;
        run_until_idle(100);
        chk("t3_all", 64'(head[3]), 64'(9));
        if (log_cyc.size() == 9) chk("t3_after_ret", 64'(log_cyc[8] >= first_ret_cyc), 64'(1));

        // read data routing: port0 size 2 then port2 size 1
        clear_test();
        add_cmd(0, 1'b1, 2);
        add_cmd(2, 1'b1, 1);
        run_until_idle(60);
        chk("t4_beats", 64'(rv_log.size()), 64'(3));
        if (rv_log.size() == 3) begin
            chk("t4_v0", 64'(rv_log[0]), 64'(4'b0001));
            chk("t4_v1", 64'(rv_log[1]), 64'(4'b0001));
            chk("t4_v2", 64'(rv_log[2]), 64'(4'b0100));
        end

        // port0 and port1 both backlogged
        clear_test();
        for (int k = 0; k < 4; k++) begin
            add_cmd(0, 1'b0, 1);
            add_cmd(1, 1'b0, 1);
        end
        run_until_idle(80);
        chk("t6_count", 64'(log_port.size()), 64'(8));
        for (int k = 0; k < 8; k++) begin
`ifdef DDR2_ARB_PORT0_PRIO_EN
            if (k < log_port.size()) chk("t6_order", 64'(log_port[k]), 64'(k >= 4));
`else
            if (k < log_port.size()) chk("t6_order", 64'(log_port[k]), 64'(k % 2));
`endif
        end

        // orphan read beat
        clear_test();
        return_en = 1'b0;
        orphan_pulse = 1'b1;
        step();
        orphan_pulse = 1'b0;
        repeat (4) step();
        chk("t5_orphan_sticky", 64'(rd_orphan_err), 64'(1));
        do_reset();

        // randomized mixed traffic
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 10; k++)
                add_cmd(p, bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        ready_pct = 70; ret_pct = 50; return_en = 1'b1;
        run_until_idle(4000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
